// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, 2-entry {pc, instr} buffer,
// redirect handling that drops responses belonging to the old path.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pc_j_valid,
    input  logic [31:0] next_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_ins_q, head_ins_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_ins_q, tail_ins_d;
    logic        push;
    logic        pop;

    // rst_n gate keeps the request quiet while reset is held
    assign imem_req = rst_n & (state_q == ISSUE) & (count_q < 2'd2)
                    & ~pc_j_valid;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = head_ins_q;
    assign instr_pc    = head_pc_q;

    assign push = (state_q == WAIT) & imem_rvalid & ~pc_j_valid
                & (count_q < 2'd2);
    assign pop  = instr_valid & instr_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            ISSUE: begin
                if (pc_j_valid) fetch_pc_d = next_pc;
                else if (imem_req) state_d = WAIT;
            end
            WAIT: begin
                if (pc_j_valid) begin
                    fetch_pc_d = next_pc;
                    state_d    = imem_rvalid ? ISSUE : DISCARD;
                end else if (imem_rvalid) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ISSUE;
                end
            end
            DISCARD: begin
                if (pc_j_valid) fetch_pc_d = next_pc;
                if (imem_rvalid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        head_pc_d  = head_pc_q;
        head_ins_d = head_ins_q;
        tail_pc_d  = tail_pc_q;
        tail_ins_d = tail_ins_q;
        if (pc_j_valid) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d  = fetch_pc_q;
                        head_ins_d = imem_rdata;
                    end else begin
                        tail_pc_d  = fetch_pc_q;
                        tail_ins_d = imem_rdata;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_pc_d  = tail_pc_q;
                    head_ins_d = tail_ins_q;
                    count_d    = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_pc_d  = fetch_pc_q;
                        head_ins_d = imem_rdata;
                    end else begin
                        head_pc_d  = tail_pc_q;
                        head_ins_d = tail_ins_q;
                        tail_pc_d  = fetch_pc_q;
                        tail_ins_d = imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            head_pc_q  <= 32'd0;
            head_ins_q <= 32'd0;
            tail_pc_q  <= 32'd0;
            tail_ins_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_pc_q  <= head_pc_d;
            head_ins_q <= head_ins_d;
            tail_pc_q  <= tail_pc_d;
            tail_ins_q <= tail_ins_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, path-level reference model feeding
// a scoreboard, and an independent monitor draining it on each handshake.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        pc_j_valid = 1'b0;
    logic [31:0] next_pc = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;

    int          vectors = 0;
    int          miscompares = 0;
    ent_t        sb[$];
    ent_t        mon_e;
    logic [31:0] exp_addr = RPC;
    logic [31:0] req_pc = 32'd0;
    logic [31:0] mem_addr = 32'd0;
    logic        outst = 1'b0;
    logic        stale = 1'b0;
    logic [31:0] key = 32'd0;
    logic        mem_en = 1'b0;
    logic        mem_rand = 1'b0;
    logic        force_rv = 1'b0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_j_valid  (pc_j_valid),
        .next_pc     (next_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // memory: answers the outstanding read, word = address ^ key
    always begin
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (force_rv) begin
            imem_rvalid = 1'b1;
        end else if (mem_en && outst) begin
            if (!mem_rand || $urandom_range(0, 2) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ key;
            end
        end else if (mem_rand && $urandom_range(0, 19) == 0) begin
            imem_rvalid = 1'b1;
        end
    end

    // reference model: fetch path = consecutive words from the last target
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_instr_pc", instr_pc, 32'd0);
            sb.delete();
            outst    = 1'b0;
            stale    = 1'b0;
            exp_addr = RPC;
        end else begin
            check("valid_vs_model", 32'(instr_valid), 32'(sb.size() != 0));
            if (outst || pc_j_valid || sb.size() >= 2)
                check("req_blocked", 32'(imem_req), 32'd0);
            if (imem_rvalid && outst) begin
                if (!pc_j_valid && !stale) begin
                    sb.push_back('{pc: req_pc, ins: req_pc ^ key});
                    exp_addr = req_pc + 32'd4;
                end
                outst = 1'b0;
            end
            if (pc_j_valid) begin
                sb.delete();
                exp_addr = next_pc;
                stale    = outst;
            end
            if (imem_req) begin
                check("req_addr", imem_addr, exp_addr);
                req_pc   = exp_addr;
                mem_addr = imem_addr;
                outst    = 1'b1;
                stale    = 1'b0;
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (rst_n && instr_valid && instr_ready && !pc_j_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_instr: got pc %h, expected none",
                         instr_pc);
            end else begin
                mon_e = sb.pop_front();
                check("instr_pc", instr_pc, mon_e.pc);
                check("instr", instr, mon_e.ins);
            end
        end
    end

    task automatic cyc(input logic j, input logic [31:0] npc,
                       input logic rdy);
        @(posedge clk);
        #2;
        pc_j_valid  = j;
        next_pc     = npc;
        instr_ready = rdy;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        pc_j_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic neg();
        @(negedge clk);
        #2;
    endtask

    initial begin
        logic       j;
        logic [31:0] npc;

        // streaming, one instruction every second cycle
        mem_en = 1'b1;
        do_reset(3);
        for (int k = 0; k < 7; k++) begin
            neg();
            check("stream_valid", 32'(instr_valid),
                  32'(k >= 2 && k % 2 == 0));
            if (k >= 2 && k % 2 == 0)
                check("stream_pc", instr_pc, 32'((k - 2) * 2));
        end

        // back-pressure fills both entries
        instr_ready = 1'b0;
        do_reset(2);
        repeat (7) @(negedge clk);
        #2;
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_req", 32'(imem_req), 32'd0);
        check("full_head", instr_pc, 32'd0);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("drain0", instr_pc, 32'd0);
        neg();
        check("drain1", instr_pc, 32'd4);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'd8);

        // redirect while waiting, then the late response is dropped
        do_reset(2);
        cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0);
        mem_en = 1'b0;
        cyc(1'b1, 32'h100, 1'b0);
        cyc(1'b0, 32'd0, 1'b1);
        mem_en = 1'b1;
        neg();
        check("flush_valid", 32'(instr_valid), 32'd0);
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h100);

        // redirect coincident with the response
        cyc(1'b1, 32'h40, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h40);
        check("coinc_valid", 32'(instr_valid), 32'd0);

        // top-of-memory wrap
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'd0);
        check("wrap_head", instr_pc, 32'hFFFF_FFFC);

        // reset mid-WAIT, stale pulse right after release
        mem_en = 1'b0;
        do_reset(2);
        cyc(1'b0, 32'd0, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, 32'd0, 1'b1);
        force_rv = 1'b1;
        cyc(1'b0, 32'd0, 1'b1);
        rst_n    = 1'b1;
        force_rv = 1'b0;
        mem_en   = 1'b1;
        neg();
        check("rst_stale_req", 32'(imem_req), 32'd1);
        check("rst_stale_addr", imem_addr, RPC);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("rst_stale_valid", 32'(instr_valid), 32'd0);
        cyc(1'b0, 32'd0, 1'b1);
        neg();
        check("rst_first_valid", 32'(instr_valid), 32'd1);
        check("rst_first_pc", instr_pc, RPC);

        // randomized traffic
        mem_en = 1'b0;
        cyc(1'b0, 32'd0, 1'b1);
        key      = $urandom;
        mem_rand = 1'b1;
        mem_en   = 1'b1;
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            j = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: npc = 32'hFFFF_FFF8;
                1: npc = $urandom;
                default: npc = $urandom & 32'hFFFF_FFFC;
            endcase
            cyc(j, npc, ($urandom_range(0, 3) != 0));
            if (i % 700 == 699) do_reset($urandom_range(1, 3));
        end
        repeat (30) cyc(1'b0, 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
